// File: rtl/event_indicator.sv
// Turns single-cycle event pulses into fixed-length LED flashes separated by a forced off gap.
// Events that arrive during a flash are counted (saturating) and replayed back to back.
//   state | meaning
//   IDLE  | LED off, nothing queued
//   ON    | LED lit for ON_CYCLES
//   GAP   | LED forced off for GAP_CYCLES
module event_indicator #(
    parameter int ON_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_in,
    input  logic              clear_ovf,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              event_prev_q;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              ev;
    logic              replay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            event_prev_q <= 1'b0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            event_prev_q <= event_in;
            led_q        <= led_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        ev         = event_in & ~event_prev_q;
        state_d    = state_q;
        timer_d    = '0;
        replay     = 1'b0;
        pending_d  = pending_q;
        overflow_d = overflow_q & ~clear_ovf;

        case (state_q)
            IDLE: begin
                if (ev) state_d = ON;
            end
            ON: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == ON_LAST) begin
                    state_d = GAP;
                    timer_d = '0;
                end
            end
            GAP: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (pending_q != '0) begin
                        state_d = ON;
                        replay  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new event on the replay edge takes the slot just freed, so the count is unchanged.
        if (state_q != IDLE && ev) begin
            if (!replay) begin
                if (pending_q == '1) overflow_d = 1'b1;
                else                 pending_d  = pending_q + PEND_W'(1);
            end
        end else if (replay) begin
            pending_d = pending_q - PEND_W'(1);
        end

        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator with ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
module tb_event_indicator;

    logic       clk = 1'b0;
    logic       rst;
    logic       event_in;
    logic       clear_ovf;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    event_indicator #(
        .ON_CYCLES (4),
        .GAP_CYCLES(2),
        .PEND_W    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .clear_ovf(clear_ovf),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        event_in  = 1'b1;
        clear_ovf = 1'b0;
        #3;
        checks++;
        if ({led_out, busy, pending, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: got led=%b busy=%b pending=%0d ovf=%b, expected all 0",
                     led_out, busy, pending, overflow);
        end
        tick();
        tick();
        event_in = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({led_out, busy, pending, overflow} !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d got led=%b busy=%b pending=%0d, expected idle",
                         i, led_out, busy, pending);
            end
        end
    endtask

    task automatic test_single();
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            if (t > 0) tick();
            checks++;
            if (led_out !== (t < 4)) begin
                errors++;
                $display("FAIL single_led: edge k+%0d got %b expected %b", t, led_out, (t < 4));
            end
            checks++;
            if (busy !== (t < 6)) begin
                errors++;
                $display("FAIL single_busy: edge k+%0d got %b expected %b", t, busy, (t < 6));
            end
        end
        checks++;
        if (pending !== 2'd0) begin
            errors++;
            $display("FAIL single_pending: got %0d expected 0", pending);
        end
    endtask

    task automatic test_held();
        int highs = 0;
        int rises = 0;
        int pend_nz = 0;
        logic last = 1'b0;
        event_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (led_out === 1'b1) highs++;
            if (led_out === 1'b1 && last === 1'b0) rises++;
            if (pending !== 2'd0) pend_nz++;
            last = led_out;
        end
        event_in = 1'b0;
        tick();
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL held_on_cycles: got %0d expected 4", highs);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL held_flashes: got %0d expected 1", rises);
        end
        checks++;
        if (pend_nz != 0) begin
            errors++;
            $display("FAIL held_pending: nonzero in %0d cycles, expected 0", pend_nz);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_busy_end: got %b expected 0", busy);
        end
    endtask

    // Events sampled at edges 0,2,4,6; edge 6 is the replay edge so the queue stays at 2.
    task automatic test_back_to_back();
        logic [1:0] exp_pend;
        for (int t = 0; t <= 24; t++) begin
            event_in = (t <= 6) && (t % 2 == 0);
            tick();
            if (t < 2)       exp_pend = 2'd0;
            else if (t < 4)  exp_pend = 2'd1;
            else if (t < 12) exp_pend = 2'd2;
            else if (t < 18) exp_pend = 2'd1;
            else             exp_pend = 2'd0;
            checks++;
            if (led_out !== ((t % 6) < 4 && t < 24)) begin
                errors++;
                $display("FAIL b2b_led: edge %0d got %b expected %b", t, led_out, ((t % 6) < 4 && t < 24));
            end
            checks++;
            if (busy !== (t < 24)) begin
                errors++;
                $display("FAIL b2b_busy: edge %0d got %b expected %b", t, busy, (t < 24));
            end
            checks++;
            if (pending !== exp_pend) begin
                errors++;
                $display("FAIL b2b_pending: edge %0d got %0d expected %0d", t, pending, exp_pend);
            end
        end
        event_in = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] ev_pat  = 16'b1010_0101_0101_0101;
        logic [15:0] clr_pat = 16'b1000_1000_0000_0000;
        int waited = 0;
        for (int t = 0; t <= 15; t++) begin
            event_in  = ev_pat[t];
            clear_ovf = clr_pat[t];
            tick();
            case (t)
                10: begin
                    checks++;
                    if (pending !== 2'd3 || overflow !== 1'b1) begin
                        errors++;
                        $display("FAIL ovf_set: got pending=%0d ovf=%b expected 3/1", pending, overflow);
                    end
                end
                11: begin
                    checks++;
                    if (overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL ovf_clear: got %b expected 0", overflow);
                    end
                end
                13: begin
                    checks++;
                    if (pending !== 2'd3 || overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL ovf_refill: got pending=%0d ovf=%b expected 3/0", pending, overflow);
                    end
                end
                15: begin
                    checks++;
                    if (pending !== 2'd3 || overflow !== 1'b1) begin
                        errors++;
                        $display("FAIL ovf_set_wins: got pending=%0d ovf=%b expected 3/1", pending, overflow);
                    end
                end
                default: ;
            endcase
        end
        event_in  = 1'b0;
        clear_ovf = 1'b0;
        while (busy === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        // Queue of 3 after edge 15 drains at edge 36, i.e. 21 cycles later.
        checks++;
        if (waited != 21) begin
            errors++;
            $display("FAIL ovf_drain_time: got %0d cycles expected 21", waited);
        end
        checks++;
        if (pending !== 2'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got pending=%0d ovf=%b expected 0/1", pending, overflow);
        end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_final_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid_flash();
        for (int t = 0; t <= 7; t++) begin
            event_in = (t <= 6) && (t % 2 == 0);
            tick();
        end
        checks++;
        if (led_out !== 1'b1 || pending !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre: got led=%b pending=%0d expected 1/2", led_out, pending);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({led_out, busy, pending, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: got led=%b busy=%b pending=%0d ovf=%b expected all 0",
                     led_out, busy, pending, overflow);
        end
        #1;
        rst = 1'b1;
        tick();
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_back_to_back();
        test_overflow();
        test_reset_mid_flash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
